// File: rtl/ad9228_fifo_drain_arbiter.sv
// Round-robin drain scheduler for the per-channel AD9228 capture FIFOs.
// Grants one channel at a time for bursts of up to BURST_LEN words, issues its
// read strobe and merges the returned words into one channel-tagged stream
// through a 2-entry output buffer.
module ad9228_fifo_drain_arbiter #(
    parameter  int NUM_CH     = 4,
    parameter  int DATA_WIDTH = 12,
    parameter  int BURST_LEN  = 16,
    localparam int CH_W       = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [NUM_CH-1:0]            ch_mask,
    input  logic [NUM_CH-1:0]            fifo_not_empty,
    input  logic [NUM_CH*DATA_WIDTH-1:0] fifo_dout,
    output logic [NUM_CH-1:0]            fifo_rd_en,
    output logic [DATA_WIDTH-1:0]        m_tdata,
    output logic [CH_W-1:0]              m_tuser,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic                         busy,
    output logic [31:0]                  word_count
);

    localparam int BC_W = $clog2(BURST_LEN + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                state;
    logic [CH_W-1:0]       gnt_ch;
    logic [CH_W-1:0]       rr_ptr;
    logic [BC_W-1:0]       burst_cnt;
    logic                  inflight;
    logic [CH_W-1:0]       inflight_ch;
    logic [1:0]            buf_cnt;
    logic [DATA_WIDTH-1:0] buf_data [2];
    logic [CH_W-1:0]       buf_tag  [2];

    logic [NUM_CH-1:0]     eligible;
    logic [CH_W-1:0]       pick;
    logic [1:0]            occ;
    logic                  has_space;
    logic                  rd_go;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] new_data;

    // First eligible channel searching upward from ptr+1, wrapping; the
    // nearest candidate is evaluated last so it wins.
    function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] elig,
                                                input logic [CH_W-1:0]   ptr);
        logic [CH_W-1:0] sel;
        int              idx;
        sel = ptr;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NUM_CH;
            if (elig[idx]) sel = CH_W'(idx);
        end
        return sel;
    endfunction

    assign eligible = {NUM_CH{enable}} & ch_mask & fifo_not_empty;
    assign pick     = rr_pick(eligible, rr_ptr);
    assign pop      = (buf_cnt != 2'd0) & m_tready;
    assign push     = inflight;
    assign new_data = fifo_dout[int'(inflight_ch)*DATA_WIDTH +: DATA_WIDTH];

    // Words already committed (buffered + in flight) less the one leaving this
    // cycle must leave a slot free, so the buffer can never overflow.
    assign occ       = buf_cnt + {1'b0, inflight};
    assign has_space = (occ - {1'b0, pop}) <= 2'd1;
    assign rd_go     = (state == GRANT) & eligible[gnt_ch] & has_space;

    // Read strobe for the granted channel only.
    always_comb begin
        fifo_rd_en = '0;
        if (rd_go) fifo_rd_en[gnt_ch] = 1'b1;
    end

    // Grant FSM: pick in IDLE, read in GRANT until burst done or channel ineligible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt_ch    <= '0;
            rr_ptr    <= CH_W'(NUM_CH - 1);
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|eligible) begin
                        gnt_ch    <= pick;
                        rr_ptr    <= pick;
                        burst_cnt <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (!eligible[gnt_ch]) begin
                        state <= IDLE;
                    end else if (rd_go) begin
                        burst_cnt <= burst_cnt + BC_W'(1);
                        if (burst_cnt == BC_W'(BURST_LEN - 1)) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Track the read issued last cycle and the channel it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight    <= 1'b0;
            inflight_ch <= '0;
        end else begin
            inflight <= rd_go;
            if (rd_go) inflight_ch <= gnt_ch;
        end
    end

    // Output buffer occupancy and accepted-word counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_cnt    <= 2'd0;
            word_count <= 32'd0;
        end else begin
            buf_cnt <= buf_cnt + {1'b0, push} - {1'b0, pop};
            if (pop) word_count <= word_count + 32'd1;
        end
    end

    // Buffer storage, FIFO ordered with entry 0 as head; contents are only
    // meaningful under buf_cnt so they carry no reset.
    always_ff @(posedge clk) begin
        if (pop) begin
            if (push && buf_cnt == 2'd1) begin
                buf_data[0] <= new_data;
                buf_tag[0]  <= inflight_ch;
            end else begin
                buf_data[0] <= buf_data[1];
                buf_tag[0]  <= buf_tag[1];
            end
            if (push && buf_cnt == 2'd2) begin
                buf_data[1] <= new_data;
                buf_tag[1]  <= inflight_ch;
            end
        end else if (push) begin
            if (buf_cnt == 2'd0) begin
                buf_data[0] <= new_data;
                buf_tag[0]  <= inflight_ch;
            end else begin
                buf_data[1] <= new_data;
                buf_tag[1]  <= inflight_ch;
            end
        end
    end

    assign m_tvalid = (buf_cnt != 2'd0);
    assign m_tdata  = m_tvalid ? buf_data[0] : '0;
    assign m_tuser  = m_tvalid ? buf_tag[0]  : '0;
    assign busy     = (state == GRANT) | inflight | (buf_cnt != 2'd0);

endmodule
